// File: rtl/demux_pkg.sv
// Shared types and helpers for the round-robin dispatch demux.
// Holds the channel count, FSM state type and the enabled-channel search.
package demux_pkg;

  localparam int NCH = 4;

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  // First enabled channel at or above start, wrapping 3->0.
  function automatic logic [1:0] next_en(
    input logic [NCH-1:0] en,
    input logic [1:0]     start
  );
    logic [1:0] idx;
    next_en = start;
    for (int i = NCH-1; i >= 0; i--) begin
      idx = start + i[1:0];
      if (en[idx]) next_en = idx;
    end
  endfunction

endpackage

// File: rtl/decoder_2to4.sv
// Gated 2-to-4 one-hot decoder.
// Output is all zero when en is low.
module decoder_2to4 (
  input  logic       en,
  input  logic [1:0] sel,
  output logic [3:0] y
);

  assign y = en ? (4'b0001 << sel) : 4'b0000;

endmodule

// File: rtl/demux_rr_dispatch.sv
// Round-robin word dispatcher onto four channels.
// Stalled words reroute on timeout or when their channel is disabled.
module demux_rr_dispatch
  import demux_pkg::*;
#(
  parameter int W       = 8,
  parameter int TIMEOUT = 15
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  input  logic [3:0]   chan_en,
  output logic [3:0]   out_valid,
  input  logic [3:0]   out_ready,
  output logic [W-1:0] out_data,
  output logic [1:0]   out_sel,
  output logic         timeout_err
);

  localparam logic [7:0] TLIM = 8'(TIMEOUT - 1);

  state_t       state, state_n;
  logic [1:0]   rr_ptr, ptr_n, sel_n;
  logic [7:0]   cnt, cnt_n;
  logic [W-1:0] data_n;
  logic         terr_n;
  logic         en_any, accept, dec_en;

  assign en_any   = |chan_en;
  assign dec_en   = (state == SEND) && en_any;
  assign accept   = dec_en && out_ready[out_sel];
  assign in_ready = (state == IDLE) && en_any;

  decoder_2to4 u_dec (
    .en  (dec_en),
    .sel (out_sel),
    .y   (out_valid)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      rr_ptr      <= 2'd0;
      out_sel     <= 2'd0;
      cnt         <= 8'd0;
      out_data    <= '0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_n;
      rr_ptr      <= ptr_n;
      out_sel     <= sel_n;
      cnt         <= cnt_n;
      out_data    <= data_n;
      timeout_err <= terr_n;
    end
  end

  always_comb begin
    state_n = state;
    ptr_n   = rr_ptr;
    sel_n   = out_sel;
    cnt_n   = cnt;
    data_n  = out_data;
    terr_n  = 1'b0;
    unique case (state)
      IDLE: begin
        if (in_valid && en_any) begin
          data_n  = in_data;
          sel_n   = next_en(chan_en, rr_ptr);
          cnt_n   = 8'd0;
          state_n = SEND;
        end
      end
      SEND: begin
        if (accept) begin
          ptr_n   = out_sel + 2'd1;
          state_n = IDLE;
        end else if (!en_any) begin
          cnt_n = cnt;
        end else if (!chan_en[out_sel]) begin
          sel_n = next_en(chan_en, out_sel + 2'd1);
          cnt_n = 8'd0;
        end else if (cnt >= TLIM) begin
          // Lone enabled channel wraps back onto itself here.
          sel_n  = next_en(chan_en, out_sel + 2'd1);
          cnt_n  = 8'd0;
          terr_n = 1'b1;
        end else begin
          cnt_n = cnt + 8'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_demux_rr_dispatch.sv
// Directed bench for demux_rr_dispatch (TIMEOUT=3).
// Snapshot = {in_ready, out_valid, out_sel, out_data, timeout_err}.
module tb_demux_rr_dispatch;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [3:0] chan_en;
  logic [3:0] out_valid;
  logic [3:0] out_ready;
  logic [7:0] out_data;
  logic [1:0] out_sel;
  logic       timeout_err;

  int n_tests = 0;
  int n_fail  = 0;
  logic [15:0] exp;

  demux_rr_dispatch #(.W(8), .TIMEOUT(3)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .chan_en     (chan_en),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_sel     (out_sel),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] snap();
    return {in_ready, out_valid, out_sel, out_data, timeout_err};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    exp = {1'b0, 4'b0000, 2'd0, 8'h00, 1'b0};
    n_tests++;
    if (snap() !== exp) begin
      n_fail++;
      $display("FAIL reset_noen got=%h want=%h", snap(), exp);
    end
    chan_en = 4'b1111;
    #1;
    exp = {1'b1, 4'b0000, 2'd0, 8'h00, 1'b0};
    n_tests++;
    if (snap() !== exp) begin
      n_fail++;
      $display("FAIL reset_en got=%h want=%h", snap(), exp);
    end
    tick();
    rst = 1'b0;
    tick();
    n_tests++;
    if (snap() !== exp) begin
      n_fail++;
      $display("FAIL reset_release got=%h want=%h", snap(), exp);
    end
  endtask

  task automatic test_rr_all();
    chan_en   = 4'b1111;
    out_ready = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      in_valid = 1'b1;
      in_data  = 8'(16 + k);
      tick();
      in_valid = 1'b0;
      exp = {1'b0, 4'(4'b0001 << (k % 4)), 2'(k % 4), 8'(16 + k), 1'b0};
      n_tests++;
      if (snap() !== exp) begin
        n_fail++;
        $display("FAIL rr_send%0d got=%h want=%h", k, snap(), exp);
      end
      tick();
      exp = {1'b1, 4'b0000, 2'(k % 4), 8'(16 + k), 1'b0};
      n_tests++;
      if (snap() !== exp) begin
        n_fail++;
        $display("FAIL rr_idle%0d got=%h want=%h", k, snap(), exp);
      end
    end
  endtask

  task automatic test_rr_sparse();
    logic [1:0] ch [3];
    ch[0] = 2'd1; ch[1] = 2'd3; ch[2] = 2'd1;
    chan_en   = 4'b1010;
    out_ready = 4'b1111;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      in_data  = 8'(160 + k);
      tick();
      in_valid = 1'b0;
      exp = {1'b0, 4'(4'b0001 << ch[k]), ch[k], 8'(160 + k), 1'b0};
      n_tests++;
      if (snap() !== exp) begin
        n_fail++;
        $display("FAIL sparse%0d got=%h want=%h", k, snap(), exp);
      end
      tick();
    end
  endtask

  task automatic test_timeout();
    chan_en   = 4'b0011;
    out_ready = 4'b0010;
    in_valid  = 1'b1;
    in_data   = 8'h55;
    tick();
    in_valid = 1'b0;
    exp = {1'b0, 4'b0001, 2'd0, 8'h55, 1'b0};
    for (int k = 0; k < 3; k++) begin
      n_tests++;
      if (snap() !== exp) begin
        n_fail++;
        $display("FAIL to_wait%0d got=%h want=%h", k, snap(), exp);
      end
      tick();
    end
    exp = {1'b0, 4'b0010, 2'd1, 8'h55, 1'b1};
    n_tests++;
    if (snap() !== exp) begin
      n_fail++;
      $display("FAIL to_reroute got=%h want=%h", snap(), exp);
    end
    tick();
    exp = {1'b1, 4'b0000, 2'd1, 8'h55, 1'b0};
    n_tests++;
    if (snap() !== exp) begin
      n_fail++;
      $display("FAIL to_done got=%h want=%h", snap(), exp);
    end
  endtask

  task automatic test_accept_on_timeout();
    out_ready = 4'b0000;
    in_valid  = 1'b1;
    in_data   = 8'h99;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    exp = {1'b0, 4'b0001, 2'd0, 8'h99, 1'b0};
    n_tests++;
    if (snap() !== exp) begin
      n_fail++;
      $display("FAIL aot_wait got=%h want=%h", snap(), exp);
    end
    out_ready = 4'b0001;
    tick();
    exp = {1'b1, 4'b0000, 2'd0, 8'h99, 1'b0};
    n_tests++;
    if (snap() !== exp) begin
      n_fail++;
      $display("FAIL aot_done got=%h want=%h", snap(), exp);
    end
  endtask

  task automatic test_disable_gap();
    chan_en   = 4'b1111;
    out_ready = 4'b1111;
    in_valid  = 1'b1;
    in_data   = 8'hB0;
    tick();
    in_valid = 1'b0;
    exp = {1'b0, 4'b0010, 2'd1, 8'hB0, 1'b0};
    n_tests++;
    if (snap() !== exp) begin
      n_fail++;
      $display("FAIL gap_pre got=%h want=%h", snap(), exp);
    end
    tick();
    out_ready = 4'b0000;
    in_valid  = 1'b1;
    in_data   = 8'hC2;
    tick();
    in_valid = 1'b0;
    exp = {1'b0, 4'b0100, 2'd2, 8'hC2, 1'b0};
    n_tests++;
    if (snap() !== exp) begin
      n_fail++;
      $display("FAIL gap_send got=%h want=%h", snap(), exp);
    end
    chan_en = 4'b0000;
    #1;
    exp = {1'b0, 4'b0000, 2'd2, 8'hC2, 1'b0};
    n_tests++;
    if (snap() !== exp) begin
      n_fail++;
      $display("FAIL gap_off got=%h want=%h", snap(), exp);
    end
    for (int k = 0; k < 5; k++) begin
      tick();
      n_tests++;
      if (snap() !== exp) begin
        n_fail++;
        $display("FAIL gap_hold%0d got=%h want=%h", k, snap(), exp);
      end
    end
    chan_en = 4'b1000;
    tick();
    exp = {1'b0, 4'b1000, 2'd3, 8'hC2, 1'b0};
    n_tests++;
    if (snap() !== exp) begin
      n_fail++;
      $display("FAIL gap_reroute got=%h want=%h", snap(), exp);
    end
    out_ready = 4'b1000;
    tick();
    exp = {1'b1, 4'b0000, 2'd3, 8'hC2, 1'b0};
    n_tests++;
    if (snap() !== exp) begin
      n_fail++;
      $display("FAIL gap_done got=%h want=%h", snap(), exp);
    end
  endtask

  task automatic test_single_channel();
    out_ready = 4'b0000;
    chan_en   = 4'b0000;
    in_valid  = 1'b1;
    in_data   = 8'h66;
    tick();
    exp = {1'b0, 4'b0000, 2'd3, 8'hC2, 1'b0};
    n_tests++;
    if (snap() !== exp) begin
      n_fail++;
      $display("FAIL one_noen got=%h want=%h", snap(), exp);
    end
    chan_en = 4'b0001;
    in_data = 8'h77;
    tick();
    in_valid = 1'b0;
    exp = {1'b0, 4'b0001, 2'd0, 8'h77, 1'b0};
    n_tests++;
    if (snap() !== exp) begin
      n_fail++;
      $display("FAIL one_send got=%h want=%h", snap(), exp);
    end
    tick();
    tick();
    tick();
    exp = {1'b0, 4'b0001, 2'd0, 8'h77, 1'b1};
    n_tests++;
    if (snap() !== exp) begin
      n_fail++;
      $display("FAIL one_reroute got=%h want=%h", snap(), exp);
    end
    tick();
    exp = {1'b0, 4'b0001, 2'd0, 8'h77, 1'b0};
    n_tests++;
    if (snap() !== exp) begin
      n_fail++;
      $display("FAIL one_pulse_end got=%h want=%h", snap(), exp);
    end
    out_ready = 4'b0001;
    tick();
    exp = {1'b1, 4'b0000, 2'd0, 8'h77, 1'b0};
    n_tests++;
    if (snap() !== exp) begin
      n_fail++;
      $display("FAIL one_done got=%h want=%h", snap(), exp);
    end
  endtask

  task automatic test_reset_mid_send();
    chan_en   = 4'b1111;
    out_ready = 4'b0000;
    in_valid  = 1'b1;
    in_data   = 8'hE1;
    tick();
    in_valid = 1'b0;
    exp = {1'b0, 4'b0010, 2'd1, 8'hE1, 1'b0};
    n_tests++;
    if (snap() !== exp) begin
      n_fail++;
      $display("FAIL rst_send got=%h want=%h", snap(), exp);
    end
    rst = 1'b1;
    #1;
    exp = {1'b1, 4'b0000, 2'd0, 8'h00, 1'b0};
    n_tests++;
    if (snap() !== exp) begin
      n_fail++;
      $display("FAIL rst_async got=%h want=%h", snap(), exp);
    end
    tick();
    rst = 1'b0;
    tick();
    n_tests++;
    if (snap() !== exp) begin
      n_fail++;
      $display("FAIL rst_after got=%h want=%h", snap(), exp);
    end
    out_ready = 4'b1111;
    in_valid  = 1'b1;
    in_data   = 8'hE2;
    tick();
    in_valid = 1'b0;
    exp = {1'b0, 4'b0001, 2'd0, 8'hE2, 1'b0};
    n_tests++;
    if (snap() !== exp) begin
      n_fail++;
      $display("FAIL rst_next got=%h want=%h", snap(), exp);
    end
    tick();
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    chan_en   = 4'b0000;
    out_ready = 4'b0000;
    test_reset();
    test_rr_all();
    test_rr_sparse();
    test_timeout();
    test_accept_on_timeout();
    test_disable_gap();
    test_single_channel();
    test_reset_mid_send();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
